pf_stride_table: RTL and testbench

PF_STRIDE_TABLE -- requirements
Module: pf_stride_table

---
 rtl/pf_stride_table.sv | 146 ++++++++++++++
 tb/tb_pf_stride_table.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pf_stride_table.sv
// pf_stride_table: direct-mapped, PC-indexed stride prefetch table.
// Retired loads train a per-PC (last_addr, stride, conf) entry. Once the
// confidence reaches ConfThr, a prediction is held in a one-deep output
// register until the consumer accepts it.
// Optional feature: define PF_STRIDE_TABLE_STATS_EN for live event counters.
module pf_stride_table #(
    parameter int unsigned Entries  = 16,
    parameter int unsigned AddrBits = 48,
    parameter int unsigned ConfThr  = 2
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                retire_valid_i,
    output logic                retire_retry_o,
    input  logic [63:0]         retire_pc_i,
    input  logic [AddrBits-1:0] retire_addr_i,
    input  logic                retire_is_load_i,
    output logic                pred_valid_o,
    input  logic                pred_retry_i,
    output logic [AddrBits-1:0] pred_addr_o,
    output logic [63:0]         pred_pc_o,
    output logic [31:0]         stat_lookups_o,
    output logic [31:0]         stat_hits_o,
    output logic [31:0]         stat_preds_o
);

    localparam int unsigned IdxW = $clog2(Entries);
    localparam int unsigned TagW = 16;
    localparam logic [1:0]  Thr  = 2'(ConfThr);

    // Table storage: only the valid bits need reset, the payload is
    // always written together with valid on an allocation.
    logic [Entries-1:0]  valid_q;
    logic [TagW-1:0]     tag_q    [Entries];
    logic [AddrBits-1:0] last_q   [Entries];
    logic [AddrBits-1:0] stride_q [Entries];
    logic [1:0]          conf_q   [Entries];

    logic                pred_valid_q;
    logic [AddrBits-1:0] pred_addr_q;
    logic [63:0]         pred_pc_q;

    logic [IdxW-1:0]     idx;
    logic [TagW-1:0]     tag;
    logic                accept;
    logic                upd;
    logic                hit;
    logic [AddrBits-1:0] delta;
    logic [AddrBits-1:0] stride_d;
    logic [1:0]          conf_d;
    logic                issue;

    logic unused_pc;
    assign unused_pc = ^{retire_pc_i[63:IdxW+18], retire_pc_i[1:0]};

    assign idx    = retire_pc_i[IdxW+1:2];
    assign tag    = retire_pc_i[IdxW+17:IdxW+2];

    // A held prediction back-pressures the retire stream; the table is
    // single-cycle read-modify-write so this is the only stall source.
    assign retire_retry_o = pred_valid_q & pred_retry_i;
    assign accept         = retire_valid_i & ~retire_retry_o;
    assign upd            = accept & retire_is_load_i;
    assign hit            = valid_q[idx] && (tag_q[idx] == tag);
    assign delta          = retire_addr_i - last_q[idx];

    // Next stride/confidence for the indexed entry.
    always_comb begin
        stride_d = stride_q[idx];
        conf_d   = conf_q[idx];
        if (!hit) begin
            stride_d = '0;
            conf_d   = 2'd0;
        end else if ((delta == stride_q[idx]) && (delta != '0)) begin
            conf_d = (conf_q[idx] == 2'd3) ? 2'd3 : conf_q[idx] + 2'd1;
        end else begin
            stride_d = delta;
            conf_d   = 2'd0;
        end
    end

    // A miss always leaves conf at 0, so only a hit can reach the threshold.
    assign issue = upd && hit && (conf_d >= Thr);

    // Entry valid bits: set on every accepted load, cleared only by reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) valid_q <= '0;
        else if (upd)  valid_q[idx] <= 1'b1;
    end

    // Entry payload: allocation and training share one write port.
    always_ff @(posedge clk_i) begin
        if (upd) begin
            tag_q[idx]    <= tag;
            last_q[idx]   <= retire_addr_i;
            stride_q[idx] <= stride_d;
            conf_q[idx]   <= conf_d;
        end
    end

    // Prediction output register: load on issue, drop once consumed,
    // hold while the consumer stalls.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pred_valid_q <= 1'b0;
            pred_addr_q  <= '0;
            pred_pc_q    <= '0;
        end else if (issue) begin
            pred_valid_q <= 1'b1;
            pred_addr_q  <= retire_addr_i + stride_d;
            pred_pc_q    <= retire_pc_i;
        end else if (!pred_retry_i) begin
            pred_valid_q <= 1'b0;
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_addr_o  = pred_addr_q;
    assign pred_pc_o    = pred_pc_q;

`ifdef PF_STRIDE_TABLE_STATS_EN
    logic [31:0] lookups_q, hits_q, preds_q;

    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lookups_q <= '0;
            hits_q    <= '0;
            preds_q   <= '0;
        end else begin
            if (upd)         lookups_q <= lookups_q + 32'd1;
            if (upd && hit)  hits_q    <= hits_q + 32'd1;
            if (issue)       preds_q   <= preds_q + 32'd1;
        end
    end

    assign stat_lookups_o = lookups_q;
    assign stat_hits_o    = hits_q;
    assign stat_preds_o   = preds_q;
`else
    assign stat_lookups_o = '0;
    assign stat_hits_o    = '0;
    assign stat_preds_o   = '0;
`endif

endmodule

// File: tb/tb_pf_stride_table.sv
// Bench for pf_stride_table: directed scenarios plus randomized traffic,
// all checked against a behavioural table model.
module tb_pf_stride_table;
    localparam int ENT = 16;
    localparam int AW  = 48;
    localparam int THR = 2;

    logic          clk = 0;
    logic          reset_n;
    logic          retire_valid, retire_retry, retire_is_load;
    logic [63:0]   retire_pc;
    logic [AW-1:0] retire_addr;
    logic          pred_valid, pred_retry;
    logic [AW-1:0] pred_addr;
    logic [63:0]   pred_pc;
    logic [31:0]   st_lk, st_hit, st_pr;

    pf_stride_table #(.Entries(ENT), .AddrBits(AW), .ConfThr(THR)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .retire_valid_i(retire_valid), .retire_retry_o(retire_retry),
        .retire_pc_i(retire_pc), .retire_addr_i(retire_addr),
        .retire_is_load_i(retire_is_load),
        .pred_valid_o(pred_valid), .pred_retry_i(pred_retry),
        .pred_addr_o(pred_addr), .pred_pc_o(pred_pc),
        .stat_lookups_o(st_lk), .stat_hits_o(st_hit), .stat_preds_o(st_pr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: one record per table slot, keyed by PC arithmetic.
    bit            m_v [ENT];
    longint        m_t [ENT];
    logic [AW-1:0] m_l [ENT];
    logic [AW-1:0] m_s [ENT];
    int            m_c [ENT];
    bit            m_pv;
    logic [AW-1:0] m_pa;
    logic [63:0]   m_pp;
    int            m_lk, m_hit, m_pr;

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) m_v[i] = 0;
        m_pv = 0; m_pa = '0; m_pp = '0;
        m_lk = 0; m_hit = 0; m_pr = 0;
    endtask

    task automatic model_step(input bit v, input logic [63:0] pc, input logic [AW-1:0] a,
                              input bit ld, input bit pr);
        bit acc, iss;
        int idx;
        longint tg;
        logic [AW-1:0] d;
        acc = v && !(m_pv && pr);
        iss = 0;
        if (acc && ld) begin
            idx = int'((pc / 4) % ENT);
            tg  = longint'((pc / (4 * ENT)) % 65536);
            m_lk++;
            if (m_v[idx] && m_t[idx] == tg) begin
                m_hit++;
                d = a - m_l[idx];
                if (d == m_s[idx] && d != 0) m_c[idx] = (m_c[idx] < 3) ? m_c[idx] + 1 : 3;
                else begin m_s[idx] = d; m_c[idx] = 0; end
                m_l[idx] = a;
                if (m_c[idx] >= THR) begin
                    iss = 1; m_pa = a + m_s[idx]; m_pp = pc; m_pr++;
                end
            end else begin
                m_v[idx] = 1; m_t[idx] = tg; m_l[idx] = a; m_s[idx] = '0; m_c[idx] = 0;
            end
        end
        if (iss) m_pv = 1;
        else if (!pr) m_pv = 0;
    endtask

    task automatic chk_stats();
`ifdef PF_STRIDE_TABLE_STATS_EN
        chk("stat_lookups", st_lk, m_lk);
        chk("stat_hits", st_hit, m_hit);
        chk("stat_preds", st_pr, m_pr);
`else
        chk("stat_lookups", st_lk, 0);
        chk("stat_hits", st_hit, 0);
        chk("stat_preds", st_pr, 0);
`endif
    endtask

    // One cycle: called just after a falling edge, returns after the next one.
    task automatic drive(input bit v, input logic [63:0] pc, input logic [AW-1:0] a,
                         input bit ld, input bit pr);
        retire_valid = v; retire_pc = pc; retire_addr = a;
        retire_is_load = ld; pred_retry = pr;
        #1;
        chk("retire_retry", retire_retry, m_pv && pr);
        model_step(v, pc, a, ld, pr);
        @(posedge clk); #1;
        chk("pred_valid", pred_valid, m_pv);
        if (m_pv) begin
            chk("pred_addr", pred_addr, m_pa);
            chk("pred_pc", pred_pc, m_pp);
        end
        chk_stats();
        @(negedge clk);
    endtask

    task automatic ld(input logic [63:0] pc, input logic [AW-1:0] a);
        drive(1, pc, a, 1, 0);
    endtask

    logic [63:0]   rpc [6];
    logic [AW-1:0] rad [6];
    logic [AW-1:0] rst_ [6];

    initial begin
        reset_n = 0; retire_valid = 0; retire_pc = '0; retire_addr = '0;
        retire_is_load = 0; pred_retry = 1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_addr", pred_addr, 0);
        chk("rst_pred_pc", pred_pc, 0);
        chk("rst_retry", retire_retry, 0);
        chk_stats();
        reset_n = 1;

        // Stride training: conf reaches 2 on the 4th load.
        ld(64'h1000, 48'h100);
        ld(64'h1000, 48'h140);
        ld(64'h1000, 48'h180);
        chk("train_no_pred", pred_valid, 0);
        ld(64'h1000, 48'h1C0);
        chk("train_p1", pred_addr, 48'h200);
        ld(64'h1000, 48'h200);
        chk("train_p2", pred_addr, 48'h240);
        ld(64'h1000, 48'h240);
        chk("train_p3", pred_addr, 48'h280);
        chk("train_pc", pred_pc, 64'h1000);
`ifdef PF_STRIDE_TABLE_STATS_EN
        chk("six_lookups", st_lk, 6);
        chk("six_hits", st_hit, 5);
        chk("six_preds", st_pr, 3);
`endif

        // Stride change restarts confidence.
        ld(64'h3004, 48'h100);
        ld(64'h3004, 48'h140);
        ld(64'h3004, 48'h150);
        ld(64'h3004, 48'h160);
        chk("chg_no_pred", pred_valid, 0);
        ld(64'h3004, 48'h170);
        chk("chg_pred", pred_addr, 48'h180);

        // Consumer stall: records are held off, prediction stays put.
        ld(64'h3004, 48'h180);
        chk("stall_pred", pred_addr, 48'h190);
        for (int i = 0; i < 5; i++) begin
            drive(1, 64'h3004, 48'h190, 1, 1);
            chk("stall_hold", pred_addr, 48'h190);
        end
        drive(1, 64'h3004, 48'h190, 1, 0);
        chk("stall_release", pred_addr, 48'h1A0);

        // Aliasing PC evicts the resident entry.
        ld(64'h1040, 48'h5000);
        ld(64'h1000, 48'h280);
        chk("alias_no_pred", pred_valid, 0);
        ld(64'h1000, 48'h2C0);
        chk("alias_retrain", pred_valid, 0);

        // Wrap-around prediction, then asynchronous reset with it pending.
        ld(64'h2008, 48'hFFFF_FFFF_FF20);
        ld(64'h2008, 48'hFFFF_FFFF_FF60);
        ld(64'h2008, 48'hFFFF_FFFF_FFA0);
        ld(64'h2008, 48'hFFFF_FFFF_FFE0);
        chk("wrap_valid", pred_valid, 1);
        chk("wrap_addr", pred_addr, 48'h20);
        retire_valid = 0; pred_retry = 1;
        #2 reset_n = 0;
        #1;
        chk("async_rst_valid", pred_valid, 0);
        chk("async_rst_addr", pred_addr, 0);
        chk("async_rst_retry", retire_retry, 0);
        model_reset();
        chk_stats();
        @(negedge clk);
        reset_n = 1;
        drive(1, 64'h2008, 48'h20, 1, 1);
        drive(1, 64'h2008, 48'h60, 1, 0);
        drive(1, 64'h2008, 48'hA0, 1, 0);
        chk("post_rst_cold", pred_valid, 0);

        // Randomized traffic: a few PCs (some aliasing) with mostly steady strides.
        rpc[0] = 64'h1000; rpc[1] = 64'h1040; rpc[2] = 64'h2008;
        rpc[3] = 64'h300C; rpc[4] = 64'h7FF0; rpc[5] = 64'h1080;
        for (int i = 0; i < 6; i++) begin
            rad[i]  = AW'({$urandom, $urandom});
            rst_[i] = AW'($urandom_range(1, 8) * 16);
        end
        for (int n = 0; n < 600; n++) begin
            int s;
            s = int'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) rst_[s] = AW'($urandom_range(0, 8) * 16);
            if (retire_retry == 0) rad[s] = rad[s] + rst_[s];
            drive($urandom_range(0, 9) < 8, rpc[s], rad[s],
                  $urandom_range(0, 9) < 9, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
